// File: rtl/electronic_to_photonic_tx.sv
// Transmit side of the electronic->photonic ALU boundary: holds one snapshot and
// frames it as SYNC, LANES-wide payload beats (LSB lanes first) and a parity beat.
module electronic_to_photonic_tx #(
    parameter int                WIDTH = 32,
    parameter int                LANES = 4,
    parameter logic [LANES-1:0]  SYNC  = 4'hA,
    parameter int                CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             link_en,
    output logic [LANES-1:0] tx_data,
    output logic             tx_valid,
    output logic             tx_sof,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [1:0]       dbg_state
);

    localparam int BEATS = WIDTH / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SYNC    = 2'd1,
        S_PAYLOAD = 2'd2,
        S_PARITY  = 2'd3
    } state_t;

    // Handshake: a word is accepted at an edge where in_valid && in_ready;
    // in_ready depends only on the registered hold_full flag.
    state_t             r_state;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;
    logic [WIDTH-1:0]   r_shift;
    logic [LANES-1:0]   r_parity;
    logic [BW-1:0]      r_beat;
    logic [LANES-1:0]   r_tx_data;
    logic               r_tx_valid;
    logic               r_tx_sof;
    logic [CNT_W-1:0]   r_frame_cnt;

    state_t             w_next_state;
    logic               w_xfer;
    logic               w_last;
    logic               w_accept;
    logic [LANES-1:0]   w_tx_data;
    logic               w_tx_valid;
    logic               w_tx_sof;

    always_comb begin
        w_next_state = r_state;
        w_tx_data    = '0;
        w_tx_valid   = 1'b0;
        w_tx_sof     = 1'b0;
        w_xfer       = r_hold_full && link_en &&
                       ((r_state == S_IDLE) || (r_state == S_PARITY));
        w_last       = (r_beat == BW'(BEATS - 1));
        w_accept     = in_valid && !r_hold_full;

        case (r_state)
            S_IDLE:    if (w_xfer) w_next_state = S_SYNC;
            S_SYNC:    w_next_state = S_PAYLOAD;
            S_PAYLOAD: if (w_last) w_next_state = S_PARITY;
            S_PARITY:  w_next_state = w_xfer ? S_SYNC : S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase

        // Outputs are those of the state being entered.
        case (w_next_state)
            S_SYNC: begin
                w_tx_data  = SYNC;
                w_tx_valid = 1'b1;
                w_tx_sof   = 1'b1;
            end
            S_PAYLOAD: begin
                w_tx_data  = r_shift[LANES-1:0];
                w_tx_valid = 1'b1;
            end
            S_PARITY: begin
                w_tx_data  = r_parity;
                w_tx_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_parity    <= '0;
            r_beat      <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_sof    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_tx_sof   <= w_tx_sof;

            if (w_xfer) begin
                r_shift     <= r_hold;
                r_parity    <= '0;
                r_beat      <= '0;
                r_hold_full <= 1'b0;
            end else if (w_next_state == S_PAYLOAD) begin
                r_shift  <= r_shift >> LANES;
                r_parity <= r_parity ^ r_shift[LANES-1:0];
                if (r_state == S_PAYLOAD) r_beat <= r_beat + BW'(1);
            end

            // Never coincides with w_xfer, which requires hold_full.
            if (w_accept) begin
                r_hold      <= in_data;
                r_hold_full <= 1'b1;
            end

            if (r_state == S_PARITY) r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign in_ready  = !r_hold_full;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign tx_sof    = r_tx_sof;
    assign busy      = (r_state != S_IDLE);
    assign frame_cnt = r_frame_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_electronic_to_photonic_tx.sv
// Bench for electronic_to_photonic_tx: frame-position reference model, directed
// scenarios, then randomized traffic; a CNT_W=2 instance shares the stimulus.
module tb_electronic_to_photonic_tx;
  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int BEATS = WIDTH / LANES;
  localparam logic [3:0] SYNC_PAT = 4'hA;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             link_en = 1'b0;

  logic             in_ready, tx_valid, tx_sof, busy;
  logic [3:0]       tx_data;
  logic [15:0]      frame_cnt;
  logic [1:0]       dbg_state;

  logic             in_ready2, tx_valid2, tx_sof2, busy2;
  logic [3:0]       tx_data2;
  logic [1:0]       frame_cnt2;
  logic [1:0]       dbg_state2;

  electronic_to_photonic_tx #(.WIDTH(WIDTH), .LANES(LANES), .SYNC(SYNC_PAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .link_en(link_en), .tx_data(tx_data), .tx_valid(tx_valid), .tx_sof(tx_sof),
    .busy(busy), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  electronic_to_photonic_tx #(.WIDTH(WIDTH), .LANES(LANES), .SYNC(SYNC_PAT), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .link_en(link_en), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_sof(tx_sof2),
    .busy(busy2), .frame_cnt(frame_cnt2), .dbg_state(dbg_state2)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model: position within the frame (-1 = idle, 0 = SYNC,
  // 1..BEATS = payload, BEATS+1 = parity) plus the holding word
  int               m_pos = -1;
  bit               m_hold_full = 1'b0;
  logic [WIDTH-1:0] m_hold = '0;
  logic [WIDTH-1:0] m_word = '0;
  int               m_frames = 0;

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] parity_of(input logic [WIDTH-1:0] w);
    logic [3:0] p = 4'h0;
    for (int i = 0; i < BEATS; i++) p = p ^ w[i*LANES +: LANES];
    return p;
  endfunction

  function automatic logic [3:0] exp_beat();
    if (m_pos < 0) return 4'h0;
    if (m_pos == 0) return SYNC_PAT;
    if (m_pos <= BEATS) return m_word[(m_pos-1)*LANES +: LANES];
    return parity_of(m_word);
  endfunction

  task automatic model_update();
    bit accept, done, start;
    if (rst) begin
      m_pos = -1; m_hold_full = 1'b0; m_frames = 0;
    end else begin
      accept = in_valid && !m_hold_full;
      done   = (m_pos == BEATS + 1);
      start  = m_hold_full && link_en && (m_pos == -1 || done);
      if (done) m_frames++;
      if (start) begin
        m_word = m_hold; m_pos = 0; m_hold_full = 1'b0;
      end else if (done) m_pos = -1;
      else if (m_pos >= 0) m_pos++;
      if (accept) begin
        m_hold = in_data; m_hold_full = 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk("tx_valid", 32'(tx_valid), 32'(m_pos >= 0));
    chk("tx_sof", 32'(tx_sof), 32'(m_pos == 0));
    chk("tx_data", 32'(tx_data), 32'(exp_beat()));
    chk("busy", 32'(busy), 32'(m_pos >= 0));
    chk("in_ready", 32'(in_ready), 32'(!m_hold_full));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames % 65536));
    chk("frame_cnt_w2", 32'(frame_cnt2), 32'(m_frames % 4));
  endtask

  // driver: one clock edge with model tracking, outputs sampled #1 after it
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic send_one(input logic [WIDTH-1:0] d);
    in_data = d; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int cnt, run, max_run;
    logic [3:0] e0;

    // reset
    rst = 1'b1;
    step(); step();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    rst = 1'b0;
    step();

    // 1: single frame
    link_en = 1'b1;
    send_one(32'h1234_5678);
    exp_q = '{4'hA, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h8};
    got_q.delete();
    for (int i = 0; i < 12; i++) begin
      step();
      if (tx_valid) got_q.push_back(tx_data);
    end
    chk("t1_beat_count", 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e0 = exp_q.pop_front();
      chk("t1_beat", 32'(got_q.pop_front()), 32'(e0));
    end
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // 2: back-to-back frames
    send_one($urandom);
    in_data = $urandom; in_valid = 1'b1;
    cnt = 0; run = 0; max_run = 0;
    for (int i = 0; i < 30; i++) begin
      bit acc;
      acc = !m_hold_full;
      step();
      if (acc) in_valid = 1'b0;
      if (tx_valid) begin
        cnt++; run++;
        if (run > max_run) max_run = run;
      end else run = 0;
    end
    chk("t2_valid_cycles", 32'(cnt), 32'd20);
    chk("t2_contiguous", 32'(max_run), 32'd20);

    // 3: word held while the link is down
    link_en = 1'b0;
    send_one($urandom);
    for (int i = 0; i < 5; i++) step();
    chk("t3_no_tx", 32'(tx_valid), 32'd0);
    chk("t3_in_ready_low", 32'(in_ready), 32'd0);
    link_en = 1'b1;
    step();
    chk("t3_sof_after_link", 32'(tx_sof), 32'd1);
    for (int i = 0; i < 11; i++) step();

    // 4: link dropped during payload beat 3
    send_one($urandom);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt += int'(tx_valid);
    end
    link_en = 1'b0;
    send_one($urandom);
    cnt += int'(tx_valid);
    for (int i = 0; i < 20; i++) begin
      step();
      cnt += int'(tx_valid);
    end
    chk("t4_full_frame", 32'(cnt), 32'd10);
    chk("t4_held", 32'(in_ready), 32'd0);
    link_en = 1'b1;
    step();
    chk("t4_resume_sof", 32'(tx_sof), 32'd1);
    for (int i = 0; i < 11; i++) step();

    // 5: reset during payload beat 4
    send_one($urandom);
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_tx_valid", 32'(tx_valid), 32'd0);
    chk("t5_tx_data", 32'(tx_data), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    step();
    chk("t5_no_partial", 32'(tx_valid), 32'd0);

    // 6: two-bit frame counter wraps
    for (int f = 0; f < 4; f++) begin
      send_one($urandom);
      for (int i = 0; i < 11; i++) step();
      chk("t6_cnt_wrap", 32'(frame_cnt2), 32'((f + 1) % 4));
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_data  = $urandom;
      in_valid = ($urandom_range(0, 2) != 0);
      link_en  = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; link_en = 1'b1;
    for (int i = 0; i < 30; i++) step();

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
